// File: rtl/avg_pool_scheduler.sv
// rtl/avg_pool_scheduler.sv - sequences average-pool layers across cores in channel batches
// Each batch: one LAUNCH gap with cores disabled, then RUN until every masked core reports done.
module avg_pool_scheduler #(
  parameter int COMPUTING_CORES    = 4,
  parameter int STATE_DATAWIDTH    = 4,
  parameter int AVG1_STATE         = 3,
  parameter int AVG2_STATE         = 6,
  parameter int AVG3_STATE         = 9,
  parameter int AVG1_CHANNELS      = 6,
  parameter int AVG2_CHANNELS      = 16,
  parameter int AVG3_CHANNELS      = 16,
  parameter int AVG_LOOP_DATAWIDTH = 3,
  parameter int CHANNEL_DATAWIDTH  = 6
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic                                           start,
  input  logic [STATE_DATAWIDTH-1:0]                     state,
  input  logic [COMPUTING_CORES-1:0]                     core_done,
  output logic [COMPUTING_CORES-1:0]                     core_enable,
  output logic [COMPUTING_CORES*CHANNEL_DATAWIDTH-1:0]   channel_index,
  output logic [AVG_LOOP_DATAWIDTH-1:0]                  avg_loop,
  output logic                                           busy,
  output logic                                           done,
  output logic                                           error
);

  localparam int NC = COMPUTING_CORES;
  localparam int CW = CHANNEL_DATAWIDTH;
  localparam int AW = AVG_LOOP_DATAWIDTH;
  // One extra bit so loop_max can equal 2**AW when avg_loop reaches its top value.
  localparam int LW = AVG_LOOP_DATAWIDTH + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  logic [1:0]     fsm_q, fsm_d;
  logic [CW-1:0]  total_q, total_d;
  logic [LW-1:0]  loop_max_q, loop_max_d;
  logic [AW-1:0]  avg_loop_q, avg_loop_d;
  logic [NC-1:0]  mask_q, mask_d;
  logic [NC-1:0]  pend_q, pend_d;
  logic [NC-1:0]  enable_q, enable_d;
  logic [NC*CW-1:0] chan_q, chan_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           error_q, error_d;

  logic           is_pool;
  logic [CW-1:0]  sel_total;
  logic [LW-1:0]  sel_loop_max;
  logic [NC-1:0]  launch_mask;
  logic [NC*CW-1:0] launch_chan;
  logic [NC-1:0]  done_now;
  logic           batch_done;
  logic           last_batch;

  always_comb begin
    is_pool   = 1'b1;
    sel_total = '0;
    if (state == STATE_DATAWIDTH'(AVG1_STATE)) begin
      sel_total = CW'(AVG1_CHANNELS);
    end else if (state == STATE_DATAWIDTH'(AVG2_STATE)) begin
      sel_total = CW'(AVG2_CHANNELS);
    end else if (state == STATE_DATAWIDTH'(AVG3_STATE)) begin
      sel_total = CW'(AVG3_CHANNELS);
    end else begin
      is_pool = 1'b0;
    end
  end

  assign sel_loop_max = LW'((32'(sel_total) + 32'(NC - 1)) / 32'(NC));

  // Core i of batch b owns channel b*NC+i; cores past the channel count sit out.
  always_comb begin
    launch_mask = '0;
    launch_chan = '0;
    for (int i = 0; i < NC; i++) begin
      launch_chan[i*CW +: CW] = CW'(32'(avg_loop_q) * 32'(NC) + 32'(i));
      launch_mask[i]          = (32'(avg_loop_q) * 32'(NC) + 32'(i)) < 32'(total_q);
    end
  end

  assign done_now   = pend_q | (core_done & mask_q);
  assign batch_done = (done_now == mask_q);
  assign last_batch = (LW'(avg_loop_q) + LW'(1)) >= loop_max_q;

  always_comb begin
    fsm_d      = fsm_q;
    total_d    = total_q;
    loop_max_d = loop_max_q;
    avg_loop_d = avg_loop_q;
    mask_d     = mask_q;
    pend_d     = pend_q;
    enable_d   = enable_q;
    chan_d     = chan_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = 1'b0;
    case (fsm_q)
      S_IDLE: begin
        if (start) begin
          if (is_pool) begin
            total_d    = sel_total;
            loop_max_d = sel_loop_max;
            avg_loop_d = '0;
            busy_d     = 1'b1;
            fsm_d      = S_LAUNCH;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      S_LAUNCH: begin
        mask_d   = launch_mask;
        chan_d   = launch_chan;
        enable_d = launch_mask;
        pend_d   = '0;
        fsm_d    = S_RUN;
      end
      S_RUN: begin
        pend_d = done_now;
        if (batch_done) begin
          enable_d = '0;
          if (last_batch) begin
            fsm_d = S_FINISH;
          end else begin
            avg_loop_d = avg_loop_q + AW'(1);
            fsm_d      = S_LAUNCH;
          end
        end
      end
      S_FINISH: begin
        done_d     = 1'b1;
        busy_d     = 1'b0;
        avg_loop_d = '0;
        fsm_d      = S_IDLE;
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q      <= S_IDLE;
      total_q    <= '0;
      loop_max_q <= '0;
      avg_loop_q <= '0;
      mask_q     <= '0;
      pend_q     <= '0;
      enable_q   <= '0;
      chan_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      total_q    <= total_d;
      loop_max_q <= loop_max_d;
      avg_loop_q <= avg_loop_d;
      mask_q     <= mask_d;
      pend_q     <= pend_d;
      enable_q   <= enable_d;
      chan_q     <= chan_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign core_enable   = enable_q;
  assign channel_index = chan_q;
  assign avg_loop      = avg_loop_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;

endmodule

// File: tb/tb_avg_pool_scheduler.sv
// tb/tb_avg_pool_scheduler.sv - scoreboard bench for avg_pool_scheduler
// Expected batches are queued at start and popped as each RUN phase appears.
module tb_avg_pool_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  state = 4'd0;
  logic [3:0]  core_done = 4'd0;
  logic [3:0]  core_enable;
  logic [23:0] channel_index;
  logic [2:0]  avg_loop;
  logic        busy;
  logic        done;
  logic        error;

  avg_pool_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .state         (state),
    .core_done     (core_done),
    .core_enable   (core_enable),
    .channel_index (channel_index),
    .avg_loop      (avg_loop),
    .busy          (busy),
    .done          (done),
    .error         (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  mask;
    logic [23:0] chans;
    logic [2:0]  loop;
  } batch_t;

  batch_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_layer(input int total);
    batch_t b;
    for (int k = 0; k < (total + 3) / 4; k++) begin
      b.loop  = 3'(k);
      b.mask  = '0;
      b.chans = '0;
      for (int i = 0; i < 4; i++) begin
        b.chans[i*6 +: 6] = 6'(k * 4 + i);
        b.mask[i]         = (k * 4 + i) < total;
      end
      exp_q.push_back(b);
    end
  endtask

  task automatic run_layer(input logic [3:0] code, input int total, input bit stagger,
                           input bit spurious, input int abort_at);
    batch_t e;
    int nb;
    int d0;
    nb = (total + 3) / 4;
    d0 = done_cnt;
    push_layer(total);
    start = 1'b1;
    state = code;
    tick;
    start = 1'b0;
    state = 4'($urandom_range(0, 15));
    check("launch_busy", busy, 1);
    check("launch_en", core_enable, 0);
    check("launch_loop", avg_loop, 0);
    for (int b = 0; b < nb; b++) begin
      tick;
      e = exp_q.pop_front();
      check("run_en", core_enable, e.mask);
      check("run_loop", avg_loop, e.loop);
      check("run_busy", busy, 1);
      for (int i = 0; i < 4; i++)
        if (e.mask[i]) check("run_chan", channel_index[i*6 +: 6], e.chans[i*6 +: 6]);
      if (b == abort_at) begin
        reset = 1'b1;
        start = 1'b1;
        state = 4'd3;
        tick;
        reset = 1'b0;
        start = 1'b0;
        check("abort_out", {core_enable, channel_index, avg_loop, busy, done, error}, 0);
        tick;
        check("abort_idle", {core_enable, busy, done, error}, 0);
        check("abort_nodone", done_cnt - d0, 0);
        exp_q.delete();
        return;
      end
      if (stagger && b == 0) begin
        core_done = 4'b0100; tick; core_done = 4'b0000;
        check("stg_en_a", core_enable, e.mask);
        core_done = 4'b1001; tick; core_done = 4'b0000;
        check("stg_en_b", core_enable, e.mask);
        core_done = 4'b0100; tick; core_done = 4'b0000;
        check("stg_en_rep", core_enable, e.mask);
        start = 1'b1; state = 4'd5; tick; start = 1'b0;
        check("stg_en_c", core_enable, e.mask);
        check("start_ignored", error, 0);
        check("stg_done", done, 0);
        core_done = 4'b0010; tick; core_done = 4'b0000;
      end else if (spurious && b == nb - 1) begin
        core_done = 4'b1000; tick; core_done = 4'b0000;
        check("spur_en", core_enable, e.mask);
        core_done = 4'b0001; tick; core_done = 4'b0000;
        check("spur_en_b", core_enable, e.mask);
        core_done = 4'b0010; tick; core_done = 4'b0000;
      end else begin
        core_done = e.mask; tick; core_done = 4'b0000;
      end
      check("cmpl_en", core_enable, 0);
      check("cmpl_done", done, 0);
      if (b < nb - 1) begin
        check("next_loop", avg_loop, b + 1);
        check("next_busy", busy, 1);
      end
    end
    tick;
    check("done_pulse", done, 1);
    check("done_busy", busy, 0);
    check("done_loop", avg_loop, 0);
    tick;
    check("done_low", done, 0);
    check("done_once", done_cnt - d0, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    tick; tick; tick;
    check("rst_out", {core_enable, channel_index, avg_loop, busy, done, error}, 0);
    reset = 1'b0;
    tick;
    check("idle_out", {core_enable, busy, done, error}, 0);

    run_layer(4'd3, 6, 1'b0, 1'b0, -1);
    run_layer(4'd6, 16, 1'b0, 1'b0, -1);

    start = 1'b1; state = 4'd5; tick; start = 1'b0;
    check("err_pulse", error, 1);
    check("err_busy", busy, 0);
    check("err_en", core_enable, 0);
    tick;
    check("err_clear", error, 0);
    check("err_busy2", busy, 0);

    run_layer(4'd9, 16, 1'b1, 1'b0, -1);
    run_layer(4'd3, 6, 1'b0, 1'b1, -1);
    run_layer(4'd9, 16, 1'b0, 1'b0, 2);
    run_layer(4'd9, 16, 1'b0, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
